// File: rtl/bcd_square.sv
// Iterative BCD squarer: BCD->binary, shift-add square, double-dabble back to BCD.
// Optional input digit check enabled by defining BCD_SQUARE_DIGIT_CHECK_EN.
module bcd_square #(
  parameter int N_IN  = 3,
  parameter int BIN_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*N_IN-1:0]   in_dec,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [8*N_IN-1:0]   out_dec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_err
);

  localparam int P_W   = 2 * BIN_W;
  localparam int D_W   = 8 * N_IN;
  localparam int SH_W  = D_W + P_W;
  localparam int CNT_W = $clog2(P_W + 1);

  typedef enum logic [2:0] {IDLE, CONV, MUL, DABBLE, DONE} state_t;

  state_t             state, state_nx;
  logic [4*N_IN-1:0]  dec_q;
  logic [BIN_W-1:0]   bin, bin_nx;
  logic [CNT_W-1:0]   cnt;
  logic [P_W-1:0]     mcand, prod, prod_nx;
  logic [BIN_W-1:0]   mplier;
  logic [SH_W-1:0]    sh, sh_adj, sh_shift;
  logic [3:0]         digit;
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
  logic               err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // DABBLE runs one extra cycle after the final shift to load out_dec.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)                     state_nx = CONV;
      CONV:    if (cnt == CNT_W'(N_IN - 1))      state_nx = MUL;
      MUL:     if (cnt == CNT_W'(BIN_W - 1))     state_nx = DABBLE;
      DABBLE:  if (cnt == CNT_W'(P_W))           state_nx = DONE;
      DONE:    if (out_ready)                    state_nx = IDLE;
      default:                                   state_nx = IDLE;
    endcase
  end

  always_comb begin
    digit   = dec_q[4*N_IN-1 -: 4];
    bin_nx  = BIN_W'(bin * BIN_W'(10)) + BIN_W'(digit);
    prod_nx = mplier[0] ? prod + mcand : prod;
    sh_adj  = sh;
    for (int i = 0; i < 2 * N_IN; i++) begin
      if (sh[P_W + 4*i +: 4] >= 4'd5)
        sh_adj[P_W + 4*i +: 4] = sh[P_W + 4*i +: 4] + 4'd3;
    end
    sh_shift = {sh_adj[SH_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= '0;
      bin     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      sh      <= '0;
      out_dec <= '0;
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dec_q <= in_dec;
            bin   <= '0;
            cnt   <= '0;
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
            err   <= 1'b0;
`endif
          end
        end
        CONV: begin
          bin   <= bin_nx;
          dec_q <= {dec_q[4*N_IN-5:0], 4'h0};
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
          if (digit > 4'd9) err <= 1'b1;
`endif
          if (cnt == CNT_W'(N_IN - 1)) begin
            cnt    <= '0;
            mcand  <= P_W'(bin_nx);
            mplier <= bin_nx;
            prod   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MUL: begin
          prod   <= prod_nx;
          mcand  <= {mcand[P_W-2:0], 1'b0};
          mplier <= {1'b0, mplier[BIN_W-1:1]};
          if (cnt == CNT_W'(BIN_W - 1)) begin
            cnt <= '0;
            sh  <= SH_W'(prod_nx);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DABBLE: begin
          if (cnt == CNT_W'(P_W)) begin
            cnt <= '0;
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
            out_dec <= err ? '0 : sh[SH_W-1 -: D_W];
`else
            out_dec <= sh[SH_W-1 -: D_W];
`endif
          end else begin
            sh  <= sh_shift;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
`ifdef BCD_SQUARE_DIGIT_CHECK_EN
  assign out_err   = (state == DONE) && err;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_square.sv
// Directed and exhaustive-root bench for bcd_square; expected squares are hand values
// or computed by a decimal reference model in this file.
module tb_bcd_square;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_dec;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_dec;
  logic        out_valid;
  logic        out_ready;
  logic        out_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_square dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dec    (in_dec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_dec   (out_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int r);
    logic [11:0] v;
    int t;
    v = '0;
    t = r;
    for (int i = 0; i < 3; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  function automatic logic [23:0] square_bcd(input int r);
    logic [23:0] v;
    int s;
    v = '0;
    s = r * r;
    for (int i = 0; i < 6; i++) begin
      v[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return v;
  endfunction

  // Waits (bounded) for in_ready, presents one operand, scrambles in_dec after
  // acceptance, then counts cycles until out_valid (bounded).
  task automatic apply_stimulus(input logic [11:0] dec, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_dec   = dec;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_dec   = dec ^ 12'h987;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_output(input string tag, input logic [23:0] exp_dec,
                              input logic exp_err, input int lat);
    check($sformatf("%s_latency", tag), 32'(lat), 32'd34);
    check($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
    check($sformatf("%s_dec", tag), 32'(out_dec), 32'(exp_dec));
    check($sformatf("%s_err", tag), 32'(out_err), 32'(exp_err));
  endtask

  // out_ready is high here, so the handshake completes on the next edge.
  task automatic handshake(input string tag);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_valid_drop", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s_ready_back", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int roots[1000];
    int j, tmp;

    rst_n     = 1'b0;
    in_dec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_dec", 32'(out_dec), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);

    apply_stimulus(12'h000, lat);
    check_output("zero", 24'h000000, 1'b0, lat);
    handshake("zero");

    apply_stimulus(12'h999, lat);
    check_output("r999", 24'h998001, 1'b0, lat);
    handshake("r999");

    apply_stimulus(12'h123, lat);
    check_output("r123", 24'h015129, 1'b0, lat);
    handshake("r123");

    apply_stimulus(12'h010, lat);
    check_output("r010", 24'h000100, 1'b0, lat);
    handshake("r010");

`ifdef BCD_SQUARE_DIGIT_CHECK_EN
    apply_stimulus(12'h1A3, lat);
    check_output("bad_digit", 24'h000000, 1'b1, lat);
    handshake("bad_digit");
    apply_stimulus(12'h003, lat);
    check_output("after_bad", 24'h000009, 1'b0, lat);
    handshake("after_bad");
`else
    // Nibble A is treated as ten, so 0x00A squares to 100.
    apply_stimulus(12'h00A, lat);
    check_output("nibble_a", 24'h000100, 1'b0, lat);
    handshake("nibble_a");
`endif

    out_ready = 1'b0;
    apply_stimulus(12'h500, lat);
    check_output("r500", 24'h250000, 1'b0, lat);
    in_dec   = 12'h002;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_dec", 32'(out_dec), 32'h250000);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    handshake("r500");
    apply_stimulus(12'h002, lat);
    check_output("r002", 24'h000004, 1'b0, lat);
    handshake("r002");

    in_dec   = 12'h777;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_dec", 32'(out_dec), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(12'h011, lat);
    check_output("r011", 24'h000121, 1'b0, lat);
    handshake("r011");

    for (int i = 0; i < 1000; i++) roots[i] = i;
    for (int i = 999; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = roots[i];
      roots[i] = roots[j];
      roots[j] = tmp;
    end
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(to_bcd3(roots[i]), lat);
      check("sweep_latency", 32'(lat), 32'd34);
      check($sformatf("sweep_%0d", roots[i]), 32'(out_dec), 32'(square_bcd(roots[i])));
      @(posedge clk);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_square.md
Name: bcd_square

Overview:
- Sequential squarer: accepts a 3-digit packed-BCD root and returns its 6-digit packed-BCD square.
- Inverse companion of the square-root finder. Sits beside it to re-square a computed root for checking, and is also used in test harnesses.
- Datapath is iterative:
  - BCD-to-binary, one digit per cycle.
  - Shift-add multiply, one bit per cycle.
  - Double-dabble binary-to-BCD, one bit per cycle.
- Valid/ready handshake on both sides.

Parameters:
- N_IN, 3: number of input BCD digits. Output has 2*N_IN digits.
- BIN_W, 10: binary width of the root; must satisfy 2^BIN_W > 10^N_IN - 1. Product width is 2*BIN_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_dec  input  4*N_IN  packed-BCD root, most significant digit in the top nibble
- in_valid  input  1  in_dec is valid
- in_ready  output  1  block can accept an operand
- out_dec  output  8*N_IN  packed-BCD square, most significant digit in the top nibble
- out_valid  output  1  out_dec is valid
- out_ready  input  1  consumer accepts out_dec
- out_err  output  1  an input digit was > 9 (only meaningful with the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_dec = 0
  - out_err = 0
  - all internal registers = 0
- States: IDLE, CONV, MUL, DABBLE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: latch in_dec, clear the accumulator, go to CONV. in_ready drops from T.
- CONV (N_IN cycles):
  - Each cycle: bin = bin*10 + next digit, most significant digit first.
  - Digit counter counts 0..N_IN-1, then go to MUL.
- MUL (BIN_W cycles):
  - Multiplicand = bin; multiplier = bin; product = 2*BIN_W bits, unsigned.
  - Each cycle: if multiplier LSB = 1, add the shifted multiplicand into product.
  - No truncation: 999*999 = 998001 fits in 20 bits.
  - Then go to DABBLE.
- DABBLE (2*BIN_W cycles):
  - Shift register = {8*N_IN BCD bits, product}.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift left by 1.
  - After the last shift, load out_dec and go to DONE.
- DONE:
  - out_valid = 1; out_dec and out_err held stable.
  - On out_valid & out_ready: out_valid = 0 next cycle, go to IDLE, in_ready = 1 next cycle.
  - If out_ready is low, the result holds indefinitely and no new operand is accepted.
- Latency: with out_ready held high, out_valid first asserts at T + N_IN + BIN_W + 2*BIN_W + 1. For defaults this is T+34.
- Throughput: one operation per 35 cycles minimum. An input is never accepted in the same cycle as output handshake completion.
- in_dec is sampled only at acceptance; later changes are ignored.
- Zero input: runs the full sequence and returns 0. No early exit, so latency is constant.
- rst_n assertion in any state: immediately returns all state and outputs to their reset values. An in-flight result is discarded.
- in_valid while busy: ignored, no queueing. The upstream block must hold in_valid until it sees in_ready.

Optional Feature:
- Macro: BCD_SQUARE_DIGIT_CHECK_EN.
- Defined:
  - During CONV, any digit > 9 sets a sticky error flag.
  - In DONE: out_err = 1 and out_dec is forced to all zeros.
  - The error flag clears on the next acceptance.
- Not defined:
  - No check; digits > 9 are used arithmetically, e.g. nibble A = 10.
  - out_err is tied to 0.
  - Latency is identical in both builds.

Test Plan:
- Reset, then in_dec=0x000 with in_valid one cycle and out_ready=1 -> out_valid at T+34, out_dec=0x000000, out_err=0, in_ready=1 one cycle after the output handshake.
- in_dec=0x999 -> out_dec=0x998001. in_dec=0x123 -> out_dec=0x015129. in_dec=0x010 -> out_dec=0x000100.
- in_dec=0x500 with out_ready=0 for 20 cycles after out_valid:
  - out_dec=0x250000 held stable and in_ready stays 0.
  - A second in_valid with 0x002 is ignored until out_ready=1.
  - After that, 0x002 returns 0x000004.
- Assert rst_n=0 during MUL after accepting 0x777 -> all outputs return to reset values immediately. After release, in_dec=0x011 returns 0x000121.
- With BCD_SQUARE_DIGIT_CHECK_EN defined: in_dec=0x1A3 -> out_err=1, out_dec=0x000000. The next operand 0x003 returns 0x000009 with out_err=0.
- Randomised sweep of all 1000 roots back-to-back, compared against a golden model -> every result equals the exact square, each with latency 34.
